// File: rtl/axis_bram_pkg.sv
// Shared definitions for the AXIS-to-BRAM writer.
//   state_t         : FSM encoding (IDLE -> WRITE -> FLUSH -> IDLE)
//   BYTES_PER_WORD  : bytes per word for the default 32-bit data path
//   WE_ALL          : all-ones byte-enable for the default data path
//   bytes_per_word(): bytes per word for any DATA_WIDTH (multiple of 8)
package axis_bram_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   localparam int unsigned DEF_DATA_WIDTH = 32;
   localparam int unsigned BYTES_PER_WORD = DEF_DATA_WIDTH / 8;
   localparam logic [BYTES_PER_WORD-1:0] WE_ALL = '1;

   function automatic int unsigned bytes_per_word(input int unsigned dw);
      return dw / 8;
   endfunction

endpackage

// File: rtl/axis_bram_writer.sv
// axis_bram_writer
//   Consumes the word stream of the upstream AXIS slave adapter and writes each
//   word into a BRAM-controller-style port (byte addressing). A transfer is armed
//   by START with a base address and word count; completion is pulsed on DONE.
// Ports
//   S_AXIS_ACLK / S_AXIS_ARESETN : clock (rising edge) / async active-low reset
//   DIN, DIN_VALID, DIN_ACCEP     : upstream word, valid, accept (combinational)
//   START, BASE_ADDR, LENGTH      : arm transfer (IDLE only), sampled on START
//   ABORT                         : end active transfer early
//   BRAM_ADDR/DIN/EN/WE           : registered BRAM port
//   BUSY, DONE, ABORTED           : status; ABORTED qualifies DONE
//   WORD_COUNT                    : words accepted in current/last transfer
module axis_bram_writer
   import axis_bram_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned LEN_WIDTH  = 16
) (
   input  logic                    S_AXIS_ACLK,
   input  logic                    S_AXIS_ARESETN,
   input  logic [DATA_WIDTH-1:0]   DIN,
   input  logic                    DIN_VALID,
   output logic                    DIN_ACCEP,
   input  logic                    START,
   input  logic [ADDR_WIDTH-1:0]   BASE_ADDR,
   input  logic [LEN_WIDTH-1:0]    LENGTH,
   input  logic                    ABORT,
   output logic [ADDR_WIDTH-1:0]   BRAM_ADDR,
   output logic [DATA_WIDTH-1:0]   BRAM_DIN,
   output logic                    BRAM_EN,
   output logic [DATA_WIDTH/8-1:0] BRAM_WE,
   output logic                    BUSY,
   output logic                    DONE,
   output logic                    ABORTED,
   output logic [LEN_WIDTH-1:0]    WORD_COUNT
);

   localparam int unsigned BPW      = bytes_per_word(DATA_WIDTH);
   localparam int unsigned ADDR_LSB = $clog2(BPW);
   localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'(BPW - 1);

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [ADDR_WIDTH-1:0]   r_base;
   logic [LEN_WIDTH-1:0]    r_len;
   logic [LEN_WIDTH-1:0]    r_count;
   logic [ADDR_WIDTH-1:0]   r_addr;
   logic [DATA_WIDTH-1:0]   r_din;
   logic                    r_en;
   logic [DATA_WIDTH/8-1:0] r_we;
   logic                    r_done;
   logic                    r_aborted;

   logic                    w_accept;
   logic                    w_hs;
   logic                    w_last;
   logic [ADDR_WIDTH-1:0]   w_wr_addr;

   // The accepted-word count doubles as the write index, so stalls never
   // advance the address and the wrap past the top is plain modulo arithmetic.
   always_comb begin
      w_accept  = (r_state == ST_WRITE) && !ABORT;
      w_hs      = w_accept && DIN_VALID;
      w_last    = w_hs && ((r_count + LEN_WIDTH'(1)) == r_len);
      w_wr_addr = r_base + (ADDR_WIDTH'(r_count) << ADDR_LSB);
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE: begin
            if (START) begin
               w_state_nxt = (LENGTH == '0) ? ST_FLUSH : ST_WRITE;
            end
         end
         ST_WRITE: begin
            if (ABORT || w_last) begin
               w_state_nxt = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
      if (!S_AXIS_ARESETN) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
      if (!S_AXIS_ARESETN) begin
         r_base    <= '0;
         r_len     <= '0;
         r_count   <= '0;
         r_addr    <= '0;
         r_din     <= '0;
         r_en      <= 1'b0;
         r_we      <= '0;
         r_done    <= 1'b0;
         r_aborted <= 1'b0;
      end else begin
         // Port strobes and DONE are single-cycle unless re-asserted below.
         r_en   <= 1'b0;
         r_we   <= '0;
         r_done <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               if (START) begin
                  r_base    <= BASE_ADDR & ADDR_MASK;
                  r_len     <= LENGTH;
                  r_count   <= '0;
                  r_aborted <= 1'b0;
               end
            end
            ST_WRITE: begin
               if (ABORT) begin
                  r_aborted <= 1'b1;
               end else if (w_hs) begin
                  r_din   <= DIN;
                  r_addr  <= w_wr_addr;
                  r_en    <= 1'b1;
                  r_we    <= '1;
                  r_count <= r_count + LEN_WIDTH'(1);
               end
            end
            ST_FLUSH: begin
               r_done <= 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   assign DIN_ACCEP  = w_accept;
   assign BRAM_ADDR  = r_addr;
   assign BRAM_DIN   = r_din;
   assign BRAM_EN    = r_en;
   assign BRAM_WE    = r_we;
   assign BUSY       = (r_state != ST_IDLE);
   assign DONE       = r_done;
   assign ABORTED    = r_aborted;
   assign WORD_COUNT = r_count;

endmodule
